reset_seq: RTL

RESET_SEQ -- requirements
Module: reset_seq

---
 rtl/reset_seq_pkg.sv | 12 +
 rtl/reset_seq.sv | 93 +++++++++
 2 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: FSM states, domain indices and cause bit positions shared by reset_seq
package reset_seq_pkg;
  typedef enum logic [2:0] {HOLD, STRETCH, REL0, REL1, REL2, RUN} state_t;
  localparam int CNT_W = 10;
  localparam int DOM_BUS = 0;
  localparam int DOM_PERIPH = 1;
  localparam int DOM_CORE = 2;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW = 1;
  localparam int CAUSE_WDT = 2;
  localparam int CAUSE_DBG = 3;
endpackage

// File: rtl/reset_seq.sv
// reset_seq: stretches reset requests, then releases bus, periph and core domains in staggered steps
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int STRETCH_CYC = 16,
  parameter int STEP_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  input  logic       dbg_rst_req,
  output logic [2:0] domain_rst_o,
  output logic       all_released,
  output logic       rst_busy,
  output logic [3:0] rst_cause
);
  if (STRETCH_CYC < 2 || STRETCH_CYC > 1023 || STEP_CYC < 1 || STEP_CYC > 1023) begin : g_bad_param
    $error("reset_seq: STRETCH_CYC or STEP_CYC out of range");
  end
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] dom_d;
  logic [3:0] req, cause_d;
  logic rel_d, req_any;
  always_comb begin
    req = '0;
    req[CAUSE_SW] = sw_rst_req;
    req[CAUSE_WDT] = wdt_rst_req;
    req[CAUSE_DBG] = dbg_rst_req;
    req_any = |req;
    state_d = state_q;
    cnt_d = cnt_q;
    dom_d = domain_rst_o;
    rel_d = all_released;
    cause_d = rst_cause;
    // Any request outside HOLD restarts the whole stretch-and-release sequence
    if (req_any && state_q != HOLD) begin
      state_d = dbg_rst_req ? HOLD : STRETCH;
      cnt_d = '0;
      dom_d = 3'b111;
      rel_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          cnt_d = '0;
          dom_d = 3'b111;
          rel_d = 1'b0;
          state_d = dbg_rst_req ? HOLD : STRETCH;
        end
        STRETCH: begin
          cnt_d = (cnt_q == STRETCH_LAST) ? '0 : cnt_q + 1'b1;
          dom_d[DOM_BUS] = cnt_q != STRETCH_LAST;
          state_d = (cnt_q == STRETCH_LAST) ? REL0 : STRETCH;
        end
        REL0: begin
          cnt_d = (cnt_q == STEP_LAST) ? '0 : cnt_q + 1'b1;
          dom_d[DOM_PERIPH] = cnt_q != STEP_LAST;
          state_d = (cnt_q == STEP_LAST) ? REL1 : REL0;
        end
        REL1: begin
          cnt_d = (cnt_q == STEP_LAST) ? '0 : cnt_q + 1'b1;
          dom_d[DOM_CORE] = cnt_q != STEP_LAST;
          rel_d = cnt_q == STEP_LAST;
          state_d = (cnt_q == STEP_LAST) ? REL2 : REL1;
        end
        REL2: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
    // A request seen in RUN starts a fresh cause history; otherwise causes accumulate
    if (req_any) cause_d = (state_q == RUN) ? req : rst_cause | req;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q <= '0;
      domain_rst_o <= 3'b111;
      all_released <= 1'b0;
      rst_busy <= 1'b1;
      rst_cause <= 4'(1 << CAUSE_POR);
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      domain_rst_o <= dom_d;
      all_released <= rel_d;
      rst_busy <= ~rel_d;
      rst_cause <= cause_d;
    end
  end
endmodule
